// File: rtl/ram_burst_reader_if.sv
// Signal bundle between ram_burst_reader and its environment: burst request, RAM read port,
// output stream and status. The reader uses the master modport, the environment uses slave.
interface ram_burst_reader_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADD_WIDTH  = 4
);
  logic                  start;
  logic [ADD_WIDTH-1:0]  base_addr;
  logic [ADD_WIDTH:0]    len;
  logic                  mem_en;
  logic [ADD_WIDTH-1:0]  mem_addr;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_last;
  logic                  busy;
  logic                  done;
  logic                  err;

  modport master (
    input  start, base_addr, len, mem_rdata, out_ready,
    output mem_en, mem_addr, out_data, out_valid, out_last, busy, done, err
  );

  modport slave (
    output start, base_addr, len, mem_rdata, out_ready,
    input  mem_en, mem_addr, out_data, out_valid, out_last, busy, done, err
  );
endinterface

// File: rtl/ram_burst_reader.sv
// Burst reader: streams len consecutive words from a 1-cycle-latency RAM through a 2-entry buffer.
// Define RAM_BURST_WRAP_EN to let bursts wrap past the top address; otherwise overruns are rejected.
module ram_burst_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int ADD_WIDTH  = 4
) (
  input logic clk,
  input logic reset,
  ram_burst_reader_if.master bus
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] READ   = 2'd1;
  localparam logic [1:0] DRAIN  = 2'd2;
  localparam logic [1:0] FINISH = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [ADD_WIDTH-1:0]  addr_q, addr_d;
  logic [ADD_WIDTH:0]    remaining_q, remaining_d;
  logic                  inflight_q, inflight_last_q;
  logic [DATA_WIDTH-1:0] data0_q, data1_q;
  logic                  last0_q, last1_q;
  logic [1:0]            count_q;
  logic                  err_q;

  logic                  pop;
  logic                  push;
  logic                  issue;
  logic                  issue_last;
  logic                  reject;
  logic [2:0]            occupancy;

  assign pop        = (count_q != 2'd0) && bus.out_ready;
  assign push       = inflight_q;
  assign occupancy  = {1'b0, count_q} + {2'b00, inflight_q};
  // Issue only if the word can still land in the buffer after this cycle's pop.
  assign issue      = (state_q == READ) && (remaining_q != '0) &&
                      (occupancy < (3'd2 + {2'b00, pop}));
  assign issue_last = issue && (remaining_q == {{ADD_WIDTH{1'b0}}, 1'b1});

`ifdef RAM_BURST_WRAP_EN
  assign reject = 1'b0;
`else
  logic [ADD_WIDTH+1:0] end_addr;
  assign end_addr = {2'b00, bus.base_addr} + {1'b0, bus.len};
  assign reject   = end_addr > {2'b01, {ADD_WIDTH{1'b0}}};
`endif

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start && !reject) begin
          addr_d      = bus.base_addr;
          remaining_d = bus.len;
          state_d     = (bus.len == '0) ? FINISH : READ;
        end
      end
      READ: begin
        if (issue) begin
          addr_d      = addr_q + 1'b1;
          remaining_d = remaining_q - 1'b1;
          if (issue_last) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && last0_q) state_d = FINISH;
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q         <= IDLE;
      addr_q          <= '0;
      remaining_q     <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      data0_q         <= '0;
      data1_q         <= '0;
      last0_q         <= 1'b0;
      last1_q         <= 1'b0;
      count_q         <= 2'd0;
      err_q           <= 1'b0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      remaining_q     <= remaining_d;
      inflight_q      <= issue;
      inflight_last_q <= issue_last;
      err_q           <= (state_q == IDLE) && bus.start && reject;
      // Entry 0 is the head; returning RAM data lands behind whatever is still buffered.
      case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) begin
            data0_q <= bus.mem_rdata;
            last0_q <= inflight_last_q;
          end else begin
            data1_q <= bus.mem_rdata;
            last1_q <= inflight_last_q;
          end
          count_q <= count_q + 2'd1;
        end
        2'b01: begin
          data0_q <= data1_q;
          last0_q <= last1_q;
          count_q <= count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd1) begin
            data0_q <= bus.mem_rdata;
            last0_q <= inflight_last_q;
          end else begin
            data0_q <= data1_q;
            last0_q <= last1_q;
            data1_q <= bus.mem_rdata;
            last1_q <= inflight_last_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.mem_en    = issue;
  assign bus.mem_addr  = issue ? addr_q : '0;
  assign bus.out_data  = data0_q;
  assign bus.out_valid = (count_q != 2'd0);
  assign bus.out_last  = (count_q != 2'd0) && last0_q;
  assign bus.busy      = (state_q == READ) || (state_q == DRAIN);
  assign bus.done      = (state_q == FINISH);
  assign bus.err       = err_q;

endmodule

// File: tb/tb_ram_burst_reader.sv
// Randomized bench for ram_burst_reader: a RAM array plus a burst-level expectation model
// (address sequence, beat order, stall hold, outstanding limit, busy/done/err timing).
module tb_ram_burst_reader;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  logic [DW-1:0] mem [DEPTH];

  ram_burst_reader_if #(.DATA_WIDTH(DW), .ADD_WIDTH(AW)) bus ();

  ram_burst_reader #(.DATA_WIDTH(DW), .ADD_WIDTH(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Synchronous RAM: data appears the cycle after the read strobe.
  always @(posedge clk) begin
    if (bus.mem_en) bus.mem_rdata <= mem[bus.mem_addr];
  end

  task automatic fill_mem();
    for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom);
  endtask

  // rdy_pct < 0 alternates out_ready 1/0; otherwise out_ready is high with that percentage.
  task automatic run_burst(input int base, input int blen, input int rdy_pct, input bit poke);
    bit            reject;
    bit            finished;
    bit            prev_stall;
    bit            prev_last;
    bit            pop;
    bit            exp_done;
    bit            exp_busy;
    bit            exp_err;
    logic [DW-1:0] prev_data;
    int            issued;
    int            accepted;
    int            last_cyc;
    int            exp_addr;
`ifdef RAM_BURST_WRAP_EN
    reject = 1'b0;
`else
    reject = (base + blen) > DEPTH;
`endif
    issued = 0; accepted = 0; last_cyc = -1; finished = 1'b0;
    prev_stall = 1'b0; prev_last = 1'b0; prev_data = '0;

    @(posedge clk); #1;
    bus.start     = 1'b1;
    bus.base_addr = AW'(base);
    bus.len       = (AW+1)'(blen);
    bus.out_ready = 1'b1;
    #1;
    total++;
    if (bus.busy !== 1'b0 || bus.mem_en !== 1'b0) begin
      bad++;
      $display("FAIL idle_at_start busy=%b mem_en=%b required 0 0", bus.busy, bus.mem_en);
    end

    for (int cyc = 1; cyc <= 300 && !finished; cyc++) begin
      @(posedge clk); #1;
      bus.start     = (poke && !reject) ? 1'($urandom) : 1'b0;
      bus.base_addr = AW'($urandom);
      bus.len       = (AW+1)'($urandom_range(DEPTH));
      bus.out_ready = (rdy_pct < 0) ? 1'(cyc % 2) : ($urandom_range(99) < rdy_pct);
      #1;
      pop = bus.out_valid && bus.out_ready;

      if (prev_stall) begin
        total++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== prev_data || bus.out_last !== prev_last) begin
          bad++;
          $display("FAIL stall_hold cyc=%0d valid=%b data=%0h last=%b required 1 %0h %b",
                   cyc, bus.out_valid, bus.out_data, bus.out_last, prev_data, prev_last);
        end
      end

      if (bus.mem_en === 1'b1) begin
        exp_addr = (base + issued) % DEPTH;
        total++;
        if (reject || issued >= blen || bus.mem_addr !== AW'(exp_addr)) begin
          bad++;
          $display("FAIL mem_addr cyc=%0d got=%0d required=%0d issued=%0d len=%0d reject=%0b",
                   cyc, bus.mem_addr, exp_addr, issued, blen, reject);
        end
        total++;
        if (issued - accepted - int'(pop) >= 2) begin
          bad++;
          $display("FAIL outstanding cyc=%0d got=%0d required<2", cyc,
                   issued - accepted - int'(pop));
        end
        issued++;
      end

      if (rdy_pct == 100 && !reject) begin
        total++;
        if (bus.mem_en !== (cyc <= blen)) begin
          bad++;
          $display("FAIL mem_en_timing cyc=%0d got=%b required=%b", cyc, bus.mem_en, cyc <= blen);
        end
        total++;
        if (bus.out_valid !== (cyc >= 3 && cyc <= blen + 2)) begin
          bad++;
          $display("FAIL valid_timing cyc=%0d got=%b required=%b", cyc, bus.out_valid,
                   cyc >= 3 && cyc <= blen + 2);
        end
      end

      if (pop) begin
        total++;
        if (accepted >= blen || bus.out_data !== mem[(base + accepted) % DEPTH]) begin
          bad++;
          $display("FAIL beat_data cyc=%0d beat=%0d got=%0h required=%0h", cyc, accepted,
                   bus.out_data, mem[(base + accepted) % DEPTH]);
        end
        total++;
        if (bus.out_last !== (accepted == blen - 1)) begin
          bad++;
          $display("FAIL beat_last cyc=%0d beat=%0d got=%b required=%b", cyc, accepted,
                   bus.out_last, accepted == blen - 1);
        end
        if (accepted == blen - 1) last_cyc = cyc;
        accepted++;
      end

      exp_done = !reject && ((blen == 0) ? (cyc == 1) : (last_cyc >= 0 && cyc == last_cyc + 1));
      exp_busy = !reject && (blen > 0) && (last_cyc < 0 || cyc == last_cyc);
      exp_err  = reject && (cyc == 1);
      total++;
      if (bus.done !== exp_done) begin
        bad++;
        $display("FAIL done cyc=%0d got=%b required=%b", cyc, bus.done, exp_done);
      end
      total++;
      if (bus.busy !== exp_busy) begin
        bad++;
        $display("FAIL busy cyc=%0d got=%b required=%b", cyc, bus.busy, exp_busy);
      end
      total++;
      if (bus.err !== exp_err) begin
        bad++;
        $display("FAIL err cyc=%0d got=%b required=%b", cyc, bus.err, exp_err);
      end

      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
      prev_last  = bus.out_last;
      if (exp_done || (reject && cyc >= 4)) finished = 1'b1;
    end
    bus.start = 1'b0;

    total++;
    if (!finished) begin
      bad++;
      $display("FAIL timeout base=%0d len=%0d issued=%0d accepted=%0d", base, blen, issued,
               accepted);
    end
    total++;
    if (issued != (reject ? 0 : blen) || accepted != (reject ? 0 : blen)) begin
      bad++;
      $display("FAIL beat_count issued=%0d accepted=%0d required=%0d", issued, accepted,
               reject ? 0 : blen);
    end
  endtask

  task automatic test_reset();
    reset         = 1'b0;
    bus.start     = 1'b1;
    bus.base_addr = 4'd5;
    bus.len       = 5'd3;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      total++;
      if ({bus.mem_en, bus.mem_addr, bus.out_data, bus.out_valid, bus.out_last, bus.busy,
           bus.done, bus.err} !== '0) begin
        bad++;
        $display("FAIL reset_outputs en=%b addr=%0h data=%0h v=%b l=%b busy=%b done=%b err=%b",
                 bus.mem_en, bus.mem_addr, bus.out_data, bus.out_valid, bus.out_last, bus.busy,
                 bus.done, bus.err);
      end
    end
    bus.start = 1'b0;
    reset     = 1'b1;
  endtask

  task automatic test_directed();
    fill_mem();
    run_burst(3, 4, 100, 1'b0);
    run_burst(15, 1, 100, 1'b0);
  endtask

  task automatic test_full_toggle();
    fill_mem();
    run_burst(0, 16, -1, 1'b0);
  endtask

  task automatic test_wrap();
    fill_mem();
    run_burst(14, 4, 100, 1'b0);
    run_burst(9, 16, 60, 1'b0);
  endtask

  task automatic test_len_zero();
    run_burst(5, 0, 100, 1'b0);
  endtask

  task automatic test_start_busy();
    fill_mem();
    run_burst(2, 6, 70, 1'b1);
  endtask

  task automatic test_reset_mid_burst();
    fill_mem();
    @(posedge clk); #1;
    bus.start     = 1'b1;
    bus.base_addr = 4'd0;
    bus.len       = 5'd8;
    bus.out_ready = 1'b1;
    for (int cyc = 1; cyc <= 4; cyc++) begin
      @(posedge clk); #1;
      bus.start = 1'b0;
    end
    #1;
    total++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== mem[1]) begin
      bad++;
      $display("FAIL second_beat valid=%b data=%0h required 1 %0h", bus.out_valid, bus.out_data,
               mem[1]);
    end
    reset = 1'b0;
    @(posedge clk); #1;
    total++;
    if ({bus.mem_en, bus.mem_addr, bus.out_data, bus.out_valid, bus.out_last, bus.busy,
         bus.done, bus.err} !== '0) begin
      bad++;
      $display("FAIL abort_outputs en=%b addr=%0h data=%0h v=%b l=%b busy=%b done=%b err=%b",
               bus.mem_en, bus.mem_addr, bus.out_data, bus.out_valid, bus.out_last, bus.busy,
               bus.done, bus.err);
    end
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      total++;
      if (bus.out_valid !== 1'b0 || bus.mem_en !== 1'b0 || bus.busy !== 1'b0) begin
        bad++;
        $display("FAIL stale_after_reset i=%0d valid=%b mem_en=%b busy=%b required 0 0 0", i,
                 bus.out_valid, bus.mem_en, bus.busy);
      end
    end
    run_burst(0, 2, 100, 1'b0);
  endtask

  task automatic test_random();
    int base;
    int blen;
    int rdy;
    for (int n = 0; n < 25; n++) begin
      base = int'($urandom_range(DEPTH - 1));
      blen = int'($urandom_range(DEPTH));
      rdy  = int'($urandom_range(100, 30));
      fill_mem();
      run_burst(base, blen, rdy, 1'($urandom));
    end
  endtask

  initial begin
    reset         = 1'b0;
    bus.start     = 1'b0;
    bus.base_addr = '0;
    bus.len       = '0;
    bus.out_ready = 1'b0;
    fill_mem();
    test_reset();
    test_directed();
    test_full_toggle();
    test_wrap();
    test_len_zero();
    test_start_busy();
    test_reset_mid_burst();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ram_burst_reader.md
RAM_BURST_READER -- requirements
Module: ram_burst_reader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, RAM word width in bits.
REQ-002 SHALL have parameter ADD_WIDTH, default 4, RAM address width; depth = 2^ADD_WIDTH.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-005 SHALL have port start  input  1  burst request, sampled only in IDLE.
REQ-006 SHALL have port base_addr  input  ADD_WIDTH  first word address, sampled with start.
REQ-007 SHALL have port len  input  ADD_WIDTH+1  beat count 0..2^ADD_WIDTH, sampled with start.
REQ-008 SHALL have port mem_en  output  1  RAM read strobe, one word per asserted cycle.
REQ-009 SHALL have port mem_addr  output  ADD_WIDTH  RAM read address, valid while mem_en=1.
REQ-010 SHALL have port mem_rdata  input  DATA_WIDTH  RAM read data, valid the cycle after mem_en.
REQ-011 SHALL have port out_data  output  DATA_WIDTH  stream beat data.
REQ-012 SHALL have port out_valid  output  1  beat available.
REQ-013 SHALL have port out_ready  input  1  consumer accepts beat.
REQ-014 SHALL have port out_last  output  1  marks final beat of burst, qualified by out_valid.
REQ-015 SHALL have port busy  output  1  high from accepted start until done.
REQ-016 SHALL have port done  output  1  one-cycle pulse at burst completion.
REQ-017 SHALL have port err  output  1  one-cycle pulse on rejected burst (REQ-035 only).

Function
REQ-018 SHALL implement FSM states IDLE, READ, DRAIN, FINISH.
REQ-019 IDLE -> READ on start=1 with len>0; start while busy SHALL be ignored.
REQ-020 start with len=0 SHALL go IDLE -> FINISH: no mem_en, no beats, done pulses next cycle.
REQ-021 First mem_en SHALL occur the cycle after start is sampled, mem_addr=base_addr.
REQ-022 Each issued read SHALL increment mem_addr by 1 (modulo 2^ADD_WIDTH, see Configuration).
REQ-023 SHALL contain 2-entry output buffer; mem_rdata written into it the cycle after its mem_en.
REQ-024 Read SHALL issue only when remaining>0 and occupancy + in_flight - (out_valid&out_ready) < 2; buffer never overflows.
REQ-025 With out_ready held 1: one beat per cycle sustained; first out_valid 3 cycles after start sampled.
REQ-026 Beat transfers when out_valid&out_ready; out_data/out_valid SHALL stay stable while out_valid&!out_ready.
REQ-027 Beats SHALL emerge in address order, exactly len beats per burst.
REQ-028 READ -> DRAIN when last read issued; DRAIN -> FINISH on handshake of out_last beat.
REQ-029 FINISH SHALL last one cycle: done=1, busy=0, then IDLE; new start accepted in the following cycle.
REQ-030 busy SHALL be 1 in READ and DRAIN, 0 in IDLE and FINISH.
REQ-031 len=2^ADD_WIDTH SHALL read entire RAM exactly once.

Reset
REQ-032 reset=0 at a rising edge SHALL force IDLE, clear buffer, in-flight and counters.
REQ-033 During/after reset: mem_en, mem_addr, out_data, out_valid, out_last, busy, done, err SHALL all be 0.
REQ-034 Reset mid-burst SHALL abort; data returning from prior mem_en SHALL be discarded.

Configuration
REQ-035 Macro RAM_BURST_WRAP_EN: defined -> addresses wrap past 2^ADD_WIDTH-1 to 0, any base_addr+len accepted; undefined -> start with base_addr+len > 2^ADD_WIDTH SHALL be rejected: no reads, err pulses the cycle after start, busy/done stay 0, state stays IDLE.

Verification
REQ-036 base=3, len=4, out_ready=1 -> mem_addr 3,4,5,6 on consecutive cycles, beats mem[3..6], out_last on 4th, done one cycle after.
REQ-037 base=0, len=16, out_ready toggling 1/0 -> 16 beats in order, no drop/duplicate, data stable while stalled, mem_en never exceeds 2 outstanding+buffered.
REQ-038 base=14, len=4: with RAM_BURST_WRAP_EN -> addrs 14,15,0,1; without -> err pulse, no mem_en, busy 0.
REQ-039 len=0 -> no mem_en, no out_valid, done pulse 1 cycle after start; start during busy -> ignored, burst unchanged.
REQ-040 reset=0 in cycle of 2nd beat of len=8 burst -> all outputs 0 next cycle, no stale beat after reset released; new burst base=0, len=2 then correct.
